// File: rtl/fact_ram_writer_if.sv
// ---------------------------------------------------------------------------
// fact_ram_writer_if
//   Single-port RAM access bus between the factorial generator and the
//   64-bit x 256 RAM.
//
//   Signals:
//     cen     chip enable, active-high (driven by master)
//     wen     write enable, 1=write 0=read, valid with cen=1 (master)
//     s_addr  RAM word address (master)
//     s_din   RAM write data (master)
//     s_dout  RAM read data, one cycle after a read access (slave)
//
//   Modports:
//     master  the generator side
//     slave   the RAM side
// ---------------------------------------------------------------------------
interface fact_ram_writer_if #(
   parameter int DW = 64,
   parameter int AW = 8
);
   logic          cen;
   logic          wen;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_din;
   logic [DW-1:0] s_dout;

   modport master (
      output cen,
      output wen,
      output s_addr,
      output s_din,
      input  s_dout
   );

   modport slave (
      input  cen,
      input  wen,
      input  s_addr,
      input  s_din,
      output s_dout
   );
endinterface

// File: rtl/fact_ram_writer.sv
// ---------------------------------------------------------------------------
// fact_ram_writer
//   On a start pulse, computes 0!, 1!, ..., n! with a bit-serial shift-add
//   multiplier and writes k! to RAM address base_addr+k (mod 2^AW).
//
//   Optional build macro: FACT_READBACK_EN
//     When defined, every write is followed by a read of the same address
//     and a compare; a mismatch sets the sticky err flag.  When undefined,
//     err is tied low and s_dout is ignored.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     start      one-cycle command, honoured only in IDLE
//     n          last factorial index, captured on start
//     base_addr  RAM address of 0!, captured on start
//     busy       high from the cycle after start until the last RAM access
//     done       one-cycle completion pulse
//     ovf        sticky: some product did not fit in DW bits
//     result     n! mod 2^DW, held until the next start
//     err        sticky readback mismatch (0 without FACT_READBACK_EN)
//     ram        RAM bus (master side)
// ---------------------------------------------------------------------------
module fact_ram_writer #(
   parameter int DW = 64,
   parameter int AW = 8,
   parameter int NW = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [NW-1:0]       n,
   input  logic [AW-1:0]       base_addr,
   output logic                busy,
   output logic                done,
   output logic                ovf,
   output logic [DW-1:0]       result,
   output logic                err,
   fact_ram_writer_if.master   ram
);

   localparam int BW = (NW > 1) ? $clog2(NW) : 1;
   localparam int PW = DW + NW;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      RD    = 3'd2,
      CMP   = 3'd3,
      MUL   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t        state;
   logic [NW-1:0] n_reg;
   logic [NW-1:0] k;
   logic [AW-1:0] base_reg;
   logic [DW-1:0] acc;
   logic [PW-1:0] prod;
   logic [BW-1:0] bit_idx;

   logic          cen_reg;
   logic          wen_reg;
   logic [AW-1:0] addr_reg;
   logic [DW-1:0] din_reg;

   logic [PW-1:0] addend;
   logic [PW-1:0] prod_next;
   logic          last_bit;

   assign ram.cen    = cen_reg;
   assign ram.wen    = wen_reg;
   assign ram.s_addr = addr_reg;
   assign ram.s_din  = din_reg;

   // One multiplier step: add acc<<bit_idx when bit bit_idx of k is set.
   // prod is wide enough that (2^DW-1)*(2^NW-1) never wraps, so the upper
   // NW bits carry the true overflow information.
   always_comb begin
      addend    = {{NW{1'b0}}, acc} << bit_idx;
      prod_next = k[bit_idx] ? (prod + addend) : prod;
      last_bit  = (bit_idx == BW'(NW - 1));
   end

`ifndef FACT_READBACK_EN
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         n_reg    <= '0;
         k        <= '0;
         base_reg <= '0;
         acc      <= '0;
         prod     <= '0;
         bit_idx  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         result   <= '0;
         cen_reg  <= 1'b0;
         wen_reg  <= 1'b0;
         addr_reg <= '0;
         din_reg  <= '0;
`ifdef FACT_READBACK_EN
         err      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n_reg    <= n;
                  base_reg <= base_addr;
                  acc      <= DW'(1);
                  k        <= '0;
                  ovf      <= 1'b0;
`ifdef FACT_READBACK_EN
                  err      <= 1'b0;
`endif
                  busy     <= 1'b1;
                  // Outputs are registered: load the first write (0! = 1)
                  // so it is on the bus during the WRITE cycle.
                  cen_reg  <= 1'b1;
                  wen_reg  <= 1'b1;
                  addr_reg <= base_addr;
                  din_reg  <= DW'(1);
                  state    <= WRITE;
               end
            end

            WRITE: begin
`ifdef FACT_READBACK_EN
               // Keep cen and the address; turn the access into a read.
               wen_reg <= 1'b0;
               state   <= RD;
`else
               cen_reg <= 1'b0;
               wen_reg <= 1'b0;
               if (k == n_reg) begin
                  result <= acc;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else begin
                  k       <= k + 1'b1;
                  prod    <= '0;
                  bit_idx <= '0;
                  state   <= MUL;
               end
`endif
            end

`ifdef FACT_READBACK_EN
            RD: begin
               cen_reg <= 1'b0;
               state   <= CMP;
            end

            CMP: begin
               // Read data from the RD access is valid in this cycle; acc
               // still holds the value that was written.
               if (ram.s_dout != acc) begin
                  err <= 1'b1;
               end
               if (k == n_reg) begin
                  result <= acc;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else begin
                  k       <= k + 1'b1;
                  prod    <= '0;
                  bit_idx <= '0;
                  state   <= MUL;
               end
            end
`endif

            MUL: begin
               prod    <= prod_next;
               bit_idx <= bit_idx + 1'b1;
               if (last_bit) begin
                  acc      <= prod_next[DW-1:0];
                  ovf      <= ovf | (|prod_next[PW-1:DW]);
                  cen_reg  <= 1'b1;
                  wen_reg  <= 1'b1;
                  addr_reg <= base_reg + AW'(k);
                  din_reg  <= prod_next[DW-1:0];
                  state    <= WRITE;
               end
            end

            DONE: begin
               // Start is not sampled here; done lands in the following
               // cycle, by which time the FSM is back in IDLE.
               done  <= 1'b1;
               state <= IDLE;
            end

            default: begin
               cen_reg <= 1'b0;
               wen_reg <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fact_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_fact_ram_writer
//   Directed bench for fact_ram_writer with a behavioural 64x256 RAM model.
//   Build with FACT_READBACK_EN defined to cover the readback variant.
// ---------------------------------------------------------------------------
module tb_fact_ram_writer;

   localparam int DW = 64;
   localparam int AW = 8;
   localparam int NW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NW-1:0] n;
   logic [AW-1:0] base_addr;
   logic          busy;
   logic          done;
   logic          ovf;
   logic [DW-1:0] result;
   logic          err;

   int total = 0;
   int bad   = 0;

   fact_ram_writer_if #(.DW(DW), .AW(AW)) ram_bus ();

   fact_ram_writer #(.DW(DW), .AW(AW), .NW(NW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n         (n),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf),
      .result    (result),
      .err       (err),
      .ram       (ram_bus.master)
   );

   always #5 clk = ~clk;

   // RAM model: synchronous write, one-cycle registered read. A read of
   // corrupt_addr can be made to return flipped data.
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] dout_q = '0;
   logic          corrupt_en = 1'b0;
   logic [AW-1:0] corrupt_addr = '0;
   logic [AW-1:0] wr_addr_log [$];
   logic [DW-1:0] wr_data_log [$];
   int            cen_cnt = 0;

   assign ram_bus.s_dout = dout_q;

   always @(posedge clk) begin
      if (ram_bus.cen === 1'b1) begin
         cen_cnt = cen_cnt + 1;
         if (ram_bus.wen === 1'b1) begin
            mem[ram_bus.s_addr] <= ram_bus.s_din;
            wr_addr_log.push_back(ram_bus.s_addr);
            wr_data_log.push_back(ram_bus.s_din);
         end else begin
            dout_q <= mem[ram_bus.s_addr] ^
                      ((corrupt_en && ram_bus.s_addr == corrupt_addr) ? 64'h1 : 64'h0);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int lat(input int nn);
`ifdef FACT_READBACK_EN
      return 4 + 9 * nn;
`else
      return 2 + 7 * nn;
`endif
   endfunction

   function automatic int accesses(input int nn);
`ifdef FACT_READBACK_EN
      return 2 * (nn + 1);
`else
      return nn + 1;
`endif
   endfunction

   // Issue start at a negedge so edge 0 samples it; returns #1 after edge 0.
   task automatic start_op(input logic [NW-1:0] nn, input logic [AW-1:0] bb);
      @(negedge clk);
      wr_addr_log.delete();
      wr_data_log.delete();
      cen_cnt   = 0;
      start     = 1'b1;
      n         = nn;
      base_addr = bb;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges after the start edge until done is seen; inj>0 injects a
   // stray start (n=2) sampled at edge inj.
   task automatic wait_done(input int inj, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         if (cyc == inj - 1) begin
            @(negedge clk);
            start     = 1'b1;
            n         = 6'd2;
            base_addr = 8'd0;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end
   endtask

   function automatic logic [63:0] wr_data(input int i);
      if (i < wr_data_log.size()) return wr_data_log[i];
      return 'x;
   endfunction

   function automatic logic [63:0] wr_addr(input int i);
      if (i < wr_addr_log.size()) return 64'(wr_addr_log[i]);
      return 'x;
   endfunction

   initial begin
      int cyc;
      logic [63:0] exp5 [6];
      logic [63:0] expa [4];
      exp5 = '{64'd1, 64'd1, 64'd2, 64'd6, 64'd24, 64'd120};
      expa = '{64'd254, 64'd255, 64'd0, 64'd1};

      // ---- reset ----
      rst = 1'b1; start = 1'b0; n = '0; base_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   64'(busy), 64'd0);
      chk("rst_done",   64'(done), 64'd0);
      chk("rst_ovf",    64'(ovf), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_cen",    64'(ram_bus.cen), 64'd0);
      chk("rst_wen",    64'(ram_bus.wen), 64'd0);
      chk("rst_addr",   64'(ram_bus.s_addr), 64'd0);
      chk("rst_din",    ram_bus.s_din, 64'd0);
      chk("rst_err",    64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_cen", 64'(cen_cnt), 64'd0);

      // ---- n=5 base 2 ----
      start_op(6'd5, 8'd2);
      chk("n5_busy_early", 64'(busy), 64'd1);
      wait_done(-1, cyc);
      chk("n5_latency", 64'(cyc), 64'(lat(5)));
      chk("n5_result", result, 64'd120);
      chk("n5_ovf", 64'(ovf), 64'd0);
      chk("n5_busy_done", 64'(busy), 64'd0);
      chk("n5_nwrites", 64'(wr_data_log.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("n5_addr%0d", i), wr_addr(i), 64'(i + 2));
         chk($sformatf("n5_data%0d", i), wr_data(i), exp5[i]);
      end
      @(posedge clk);
      #1;
      chk("n5_done_pulse", 64'(done), 64'd0);

      // ---- n=0 base 9 ----
      start_op(6'd0, 8'd9);
      wait_done(-1, cyc);
      chk("n0_latency", 64'(cyc), 64'(lat(0)));
      chk("n0_nwrites", 64'(wr_data_log.size()), 64'd1);
      chk("n0_addr", wr_addr(0), 64'd9);
      chk("n0_data", wr_data(0), 64'd1);
      chk("n0_cen_cnt", 64'(cen_cnt), 64'(accesses(0)));
      chk("n0_result", result, 64'd1);

      // ---- n=20, n=21 overflow, n=3 clears ----
      start_op(6'd20, 8'd30);
      wait_done(-1, cyc);
      chk("n20_result", result, 64'd2432902008176640000);
      chk("n20_ovf", 64'(ovf), 64'd0);
      start_op(6'd21, 8'd30);
      wait_done(-1, cyc);
      chk("n21_result", result, 64'd14197454024290336768);
      chk("n21_ovf", 64'(ovf), 64'd1);
      start_op(6'd3, 8'd30);
      chk("n3_ovf_clear", 64'(ovf), 64'd0);
      wait_done(-1, cyc);
      chk("n3_result", result, 64'd6);
      chk("n3_ovf", 64'(ovf), 64'd0);

      // ---- address wrap ----
      start_op(6'd3, 8'd254);
      wait_done(-1, cyc);
      chk("wrap_nwrites", 64'(wr_data_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_addr%0d", i), wr_addr(i), expa[i]);
         chk($sformatf("wrap_data%0d", i), wr_data(i), exp5[i]);
      end

      // ---- start while busy ignored ----
      start_op(6'd10, 8'd40);
      wait_done(5, cyc);
      chk("ign_latency", 64'(cyc), 64'(lat(10)));
      chk("ign_result", result, 64'd3628800);
      chk("ign_nwrites", 64'(wr_data_log.size()), 64'd11);
      repeat (3) @(posedge clk);
      #1;
      chk("ign_no_restart", 64'(busy), 64'd0);

      // ---- reset mid-run ----
      start_op(6'd10, 8'd100);
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy",   64'(busy), 64'd0);
      chk("abort_done",   64'(done), 64'd0);
      chk("abort_ovf",    64'(ovf), 64'd0);
      chk("abort_result", result, 64'd0);
      chk("abort_cen",    64'(ram_bus.cen), 64'd0);
      chk("abort_wen",    64'(ram_bus.wen), 64'd0);
      chk("abort_addr",   64'(ram_bus.s_addr), 64'd0);
      chk("abort_din",    ram_bus.s_din, 64'd0);
      chk("abort_err",    64'(err), 64'd0);
      cen_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_access", 64'(cen_cnt), 64'd0);
      start_op(6'd2, 8'd0);
      wait_done(-1, cyc);
      chk("after_abort_latency", 64'(cyc), 64'(lat(2)));
      chk("after_abort_result", result, 64'd2);

`ifdef FACT_READBACK_EN
      // ---- readback clean ----
      start_op(6'd4, 8'd50);
      wait_done(-1, cyc);
      chk("rb_latency", 64'(cyc), 64'd40);
      chk("rb_err_clean", 64'(err), 64'd0);
      chk("rb_result", result, 64'd24);
      chk("rb_cen_cnt", 64'(cen_cnt), 64'd10);

      // ---- readback corrupted at k=2 ----
      corrupt_en   = 1'b1;
      corrupt_addr = 8'd52;
      start_op(6'd4, 8'd50);
      wait_done(-1, cyc);
      chk("rb_err_set", 64'(err), 64'd1);
      corrupt_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rb_err_held", 64'(err), 64'd1);
      start_op(6'd1, 8'd50);
      chk("rb_err_cleared", 64'(err), 64'd0);
      wait_done(-1, cyc);
      chk("rb_err_after", 64'(err), 64'd0);
`else
      chk("err_tied", 64'(err), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
